// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage of the 5-stage RV32I pipeline.
// Drives a req/gnt/rvalid data bus for loads and stores.
// Steers store bytes onto the bus lanes and extends load data.
// Drops misaligned accesses, stalls the pipe while the bus is busy,
// abandons an access after TIMEOUT_CYC cycles, and owns MEM/WB.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regwriteM,
  input  logic        memrwM,
  input  logic        memrdM,
  input  logic [1:0]  wbselM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  rdM,
  input  logic [31:0] ALUresM,
  input  logic [31:0] data_writeM,
  input  logic [31:0] pc4M,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        stallM,
  output logic        regwriteW,
  output logic [4:0]  rdW,
  output logic [31:0] resultW,
  output logic        misalignW,
  output logic        buserrW
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC + 1) < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } lsuState_t;

  lsuState_t        state;
  lsuState_t        stateNext;
  logic [CNT_W-1:0] toCnt;

  logic        access;
  logic        misaligned;
  logic        misAccess;
  logic        alignedAccess;
  logic        timeoutHit;
  logic        reqComb;
  logic        stallComb;
  logic [1:0]  addrOff;
  logic [31:0] loadData;
  logic [31:0] resultNext;

  // H/HU need an even address, W (and any undefined funct3) needs word alignment.
  function automatic logic isMisaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      3'b000, 3'b100: mis = 1'b0;
      3'b001, 3'b101: mis = off[0];
      default:        mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte enables for a store of the given size at the given lane offset.
  function automatic logic [3:0] storeStrb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] strb;
    case (f3)
      3'b000:  strb = 4'b0001 << off;
      3'b001:  strb = off[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Store data replicated across lanes so the strobes pick the right copy.
  function automatic logic [31:0] storeData(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      3'b000:  w = {4{d[7:0]}};
      3'b001:  w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Select the addressed lane of the read word and sign/zero extend it.
  function automatic logic [31:0] loadExtend(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = rd[7:0];
      2'b01:   b = rd[15:8];
      2'b10:   b = rd[23:16];
      2'b11:   b = rd[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h000000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  assign addrOff       = ALUresM[1:0];
  assign access        = memrwM | memrdM;
  assign misaligned    = isMisaligned(funct3M, addrOff);
  assign misAccess     = access & misaligned;
  assign alignedAccess = access & ~misaligned;
  assign loadData      = loadExtend(funct3M, addrOff, dbus_rdata);

  // Bus handshake sequencing: request, stall and next-state decisions.
  always_comb begin
    stateNext  = state;
    reqComb    = 1'b0;
    stallComb  = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: begin
        if (alignedAccess) begin
          reqComb = 1'b1;
          if (dbus_gnt) begin
            if (memrwM) begin
              stallComb = 1'b0;
              stateNext = IDLE;
            end else begin
              stallComb = 1'b1;
              stateNext = WAIT_R;
            end
          end else begin
            stallComb = 1'b1;
            stateNext = REQ;
          end
        end else begin
          stateNext = IDLE;
        end
      end
      REQ: begin
        if (toCnt == TO_LIMIT) begin
          timeoutHit = 1'b1;
          stateNext  = IDLE;
        end else begin
          reqComb = 1'b1;
          if (dbus_gnt) begin
            if (memrwM) begin
              stallComb = 1'b0;
              stateNext = IDLE;
            end else begin
              stallComb = 1'b1;
              stateNext = WAIT_R;
            end
          end else begin
            stallComb = 1'b1;
            stateNext = REQ;
          end
        end
      end
      WAIT_R: begin
        if (toCnt == TO_LIMIT) begin
          timeoutHit = 1'b1;
          stateNext  = IDLE;
        end else if (dbus_rvalid) begin
          stateNext = IDLE;
        end else begin
          stallComb = 1'b1;
          stateNext = WAIT_R;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign dbus_req   = reqComb;
  assign dbus_we    = reqComb & memrwM;
  assign dbus_addr  = reqComb ? {ALUresM[31:2], 2'b00} : 32'h0000_0000;
  assign dbus_wdata = (reqComb & memrwM) ? storeData(funct3M, data_writeM) : 32'h0000_0000;
  assign dbus_wstrb = (reqComb & memrwM) ? storeStrb(funct3M, addrOff) : 4'b0000;
  assign stallM     = stallComb;

  // Writeback value selection.
  always_comb begin
    resultNext = 32'h0000_0000;
    case (wbselM)
      2'b00:   resultNext = loadData;
      2'b01:   resultNext = ALUresM;
      2'b10:   resultNext = pc4M;
      2'b11:   resultNext = 32'h0000_0000;
      default: resultNext = 32'h0000_0000;
    endcase
  end

  // FSM state and timeout counter (counter runs only while the bus is owed a reply).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      toCnt <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE) begin
        toCnt <= '0;
      end else begin
        toCnt <= toCnt + CNT_W'(1);
      end
    end
  end

  // MEM/WB register: advances when not stalled, otherwise takes a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwriteW <= 1'b0;
      rdW       <= 5'd0;
      resultW   <= 32'h0000_0000;
      misalignW <= 1'b0;
      buserrW   <= 1'b0;
    end else if (!stallComb) begin
      regwriteW <= regwriteM & ~misAccess & ~timeoutHit;
      rdW       <= rdM;
      resultW   <= resultNext;
      misalignW <= misAccess & ~timeoutHit;
      buserrW   <= timeoutHit;
    end else begin
      regwriteW <= 1'b0;
      misalignW <= 1'b0;
      buserrW   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed vectors for the MEM stage load/store unit.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst_n;
  logic        regwriteM;
  logic        memrwM;
  logic        memrdM;
  logic [1:0]  wbselM;
  logic [2:0]  funct3M;
  logic [4:0]  rdM;
  logic [31:0] ALUresM;
  logic [31:0] data_writeM;
  logic [31:0] pc4M;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        stallM;
  logic        regwriteW;
  logic [4:0]  rdW;
  logic [31:0] resultW;
  logic        misalignW;
  logic        buserrW;

  int checkCnt;
  int failCnt;
  int stallCyc;

  mem_stage_lsu #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .regwriteM(regwriteM), .memrwM(memrwM), .memrdM(memrdM), .wbselM(wbselM),
    .funct3M(funct3M), .rdM(rdM), .ALUresM(ALUresM), .data_writeM(data_writeM), .pc4M(pc4M),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_wstrb(dbus_wstrb), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .stallM(stallM), .regwriteW(regwriteW), .rdW(rdW), .resultW(resultW),
    .misalignW(misalignW), .buserrW(buserrW)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setOp(input logic rw, input logic st, input logic ld, input logic [1:0] wb,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc);
    regwriteM = rw; memrwM = st; memrdM = ld; wbselM = wb; funct3M = f3;
    rdM = rd; ALUresM = alu; data_writeM = wd; pc4M = pc;
  endtask

  task automatic clearOp();
    setOp(1'b0, 1'b0, 1'b0, 2'b11, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    checkCnt = 0; failCnt = 0;
    rst_n = 1'b0;
    clearOp();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    checkVal("rst_regwriteW", {31'd0, regwriteW}, 32'd0);
    checkVal("rst_resultW", resultW, 32'd0);
    checkVal("rst_flags", {30'd0, misalignW, buserrW}, 32'd0);
    checkVal("rst_req_stall", {30'd0, dbus_req, stallM}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1. SW 0xDEADBEEF @0x100, gnt same cycle
    setOp(1'b0, 1'b1, 1'b0, 2'b01, 3'b010, 5'd0, 32'h100, 32'hDEADBEEF, 32'h0);
    dbus_gnt = 1'b1;
    #2;
    checkVal("sw_req_we", {30'd0, dbus_req, dbus_we}, 32'd3);
    checkVal("sw_wstrb", {28'd0, dbus_wstrb}, 32'hF);
    checkVal("sw_wdata", dbus_wdata, 32'hDEADBEEF);
    checkVal("sw_addr", dbus_addr, 32'h100);
    checkVal("sw_stall", {31'd0, stallM}, 32'd0);
    step();
    clearOp(); dbus_gnt = 1'b0;
    checkVal("sw_regwriteW", {31'd0, regwriteW}, 32'd0);
    #2;
    checkVal("sw_after_stall", {31'd0, stallM}, 32'd0);
    step();

    // 2. LB / LBU @0x103, rdata 0x80FFFF7F, gnt same cycle, rvalid next
    for (int k = 0; k < 2; k++) begin
      setOp(1'b1, 1'b0, 1'b1, 2'b00, (k == 0) ? 3'b000 : 3'b100, 5'd5, 32'h103, 32'h0, 32'h0);
      dbus_gnt = 1'b1;
      #2;
      checkVal("lb_stall0", {31'd0, stallM}, 32'd1);
      checkVal("lb_req", {30'd0, dbus_req, dbus_we}, 32'd2);
      checkVal("lb_addr_wstrb", {dbus_addr[31:4], dbus_wstrb}, 32'h00000100 >> 0);
      step();
      dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h80FFFF7F;
      checkVal("lb_bubble", {31'd0, regwriteW}, 32'd0);
      #2;
      checkVal("lb_stall1", {30'd0, stallM, dbus_req}, 32'd0);
      step();
      clearOp(); dbus_rvalid = 1'b0;
      checkVal((k == 0) ? "lb_result" : "lbu_result", resultW, (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
      checkVal("lb_wb", {26'd0, regwriteW, rdW}, {26'd0, 1'b1, 5'd5});
    end
    step();

    // 3. SH 0x1234 @0x202, gnt after 3 cycles
    setOp(1'b0, 1'b1, 1'b0, 2'b01, 3'b001, 5'd0, 32'h202, 32'h00001234, 32'h0);
    dbus_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      checkVal("sh_stall", {30'd0, stallM, dbus_req}, 32'd3);
      checkVal("sh_addr", dbus_addr, 32'h200);
      checkVal("sh_wstrb", {28'd0, dbus_wstrb}, 32'hC);
      checkVal("sh_wdata", dbus_wdata, 32'h12341234);
      step();
    end
    dbus_gnt = 1'b1;
    #2;
    checkVal("sh_gnt", {30'd0, stallM, dbus_req}, 32'd1);
    step();
    clearOp(); dbus_gnt = 1'b0;
    checkVal("sh_regwriteW", {31'd0, regwriteW}, 32'd0);
    #2;
    checkVal("sh_idle", {30'd0, stallM, dbus_req}, 32'd0);
    step();

    // 4. LW @0x101 misaligned
    setOp(1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 5'd7, 32'h101, 32'h0, 32'h0);
    dbus_gnt = 1'b1;
    #2;
    checkVal("mis_req_stall", {30'd0, dbus_req, stallM}, 32'd0);
    step();
    clearOp(); dbus_gnt = 1'b0;
    checkVal("mis_pulse", {30'd0, misalignW, regwriteW}, 32'd2);
    step();
    checkVal("mis_clear", {31'd0, misalignW}, 32'd0);

    // 5. LW @0x200, gnt but no rvalid: 1 IDLE stall + 8 WAIT_R stalls, released at count 8
    setOp(1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 5'd9, 32'h200, 32'h0, 32'h0);
    dbus_gnt = 1'b1;
    stallCyc = 0;
    while (stallCyc < 20) begin
      #2;
      if (!stallM) break;
      stallCyc++;
      step();
      dbus_gnt = 1'b0;
    end
    checkVal("to_stall_cycles", stallCyc, 32'd9);
    step();
    clearOp();
    checkVal("to_buserr", {30'd0, buserrW, regwriteW}, 32'd2);
    step();
    checkVal("to_buserr_clear", {31'd0, buserrW}, 32'd0);

    // 5b. reset in the middle of WAIT_R
    setOp(1'b1, 1'b0, 1'b1, 2'b00, 3'b010, 5'd9, 32'h200, 32'h0, 32'h0);
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0;
    #2;
    checkVal("rr_wait_stall", {31'd0, stallM}, 32'd1);
    rst_n = 1'b0;
    clearOp();
    #1;
    checkVal("rr_regs", {resultW[31:8], 1'b0, rdW, misalignW, buserrW}, 32'd0);
    checkVal("rr_resultW", resultW, 32'd0);
    checkVal("rr_comb", {29'd0, dbus_req, stallM, regwriteW}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    dbus_gnt = 1'b1; dbus_rvalid = 1'b1;
    #2;
    checkVal("rr_stray", {30'd0, dbus_req, stallM}, 32'd0);
    step();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    checkVal("rr_stray_wb", {31'd0, regwriteW}, 32'd0);

    // 6. ADD then JAL then wbsel 11
    setOp(1'b1, 1'b0, 1'b0, 2'b01, 3'b000, 5'd3, 32'h5, 32'h0, 32'h0);
    #2;
    checkVal("add_stall", {31'd0, stallM}, 32'd0);
    step();
    setOp(1'b1, 1'b0, 1'b0, 2'b10, 3'b000, 5'd1, 32'h123, 32'h0, 32'h44);
    checkVal("add_result", resultW, 32'd5);
    checkVal("add_wb", {26'd0, regwriteW, rdW}, {26'd0, 1'b1, 5'd3});
    #2;
    checkVal("jal_stall", {31'd0, stallM}, 32'd0);
    step();
    setOp(1'b1, 1'b0, 1'b0, 2'b11, 3'b000, 5'd2, 32'h77, 32'h0, 32'h88);
    checkVal("jal_result", resultW, 32'h44);
    checkVal("jal_wb", {26'd0, regwriteW, rdW}, {26'd0, 1'b1, 5'd1});
    step();
    clearOp();
    checkVal("zero_result", resultW, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
    $finish;
  end

endmodule
